mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the core's single memory port (mem_addr / out_bus / in_bus) between the instruction-fetch requester and the load/store data requester.
- Sits between the multi-cycle RV32 core and instruction/data memory.
- Serializes accesses and holds memory strobes until the memory acknowledges.
- Enforces fairness (anti-starvation) and a bus timeout.

Parameters:
- XLEN, 32, address and data width.
- MAX_D_STREAK, 3, consecutive data grants allowed while a fetch is pending before fetch is forced.
- TIMEOUT, 16, cycles in a busy state without mem_ready before the access is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  XLEN  fetch address, word aligned; stable while if_req is high.
- if_gnt  out  1  one-cycle pulse when fetch is accepted.
- if_done  out  1  one-cycle pulse when fetch completes.
- if_rdata  out  XLEN  fetched instruction; valid with if_done.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  byte enables for stores.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_gnt  out  1  one-cycle pulse when the data request is accepted.
- d_done  out  1  one-cycle pulse when the data access completes.
- d_rdata  out  XLEN  load data; valid with d_done.
- err  out  1  pulses with the done pulse of an aborted access.
- mem_addr  out  XLEN  memory address.
- out_bus  out  XLEN  write data to memory.
- mem_be  out  4  write byte enables.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- in_bus  in  XLEN  read data from memory.
- mem_ready  in  1  memory acknowledge.

Behaviour:
- Clocking and reset: one clock, clk. Reset port rst is asynchronous and active-high.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Streak and timeout counters 0.
  - Reset mid-access aborts immediately with no done pulse; the requester re-requests after reset.
- FSM states:
  - IDLE: no access in flight. Arbitrate when any req is high.
  - IF_BUSY: fetch access driving the memory port.
  - D_BUSY: data access driving the memory port.
- Arbitration (IDLE only, evaluated each cycle):
  - Only if_req high: grant fetch.
  - Only d_req high: grant data.
  - Both high: grant data unless d_streak == MAX_D_STREAK, then grant fetch.
  - d_streak increments on each data grant made while if_req is high, saturates at MAX_D_STREAK, and clears on any fetch grant.
- Grant cycle (IDLE edge):
  - Pulse the matching *_gnt.
  - Latch address, we, be and wdata into internal registers.
  - Move to IF_BUSY or D_BUSY.
- Busy state outputs (all from registers, never combinational from requester inputs):
  - mem_addr = latched address.
  - mem_rd = 1 for fetch or load; mem_wr = 1 for store.
  - out_bus / mem_be = latched wdata / be for stores, 0 otherwise.
- Completion: on the edge where mem_ready = 1 in a busy state:
  - Capture in_bus into the matching rdata (stores leave rdata unchanged).
  - Pulse the matching *_done next cycle.
  - Drop strobes; return to IDLE.
  - Minimum 1 idle cycle between accesses, so the fastest access is gnt at T, done at T+2 with mem_ready high at T+1.
- Timeout:
  - The counter increments each busy cycle with mem_ready = 0.
  - At TIMEOUT-1 the access is aborted: return to IDLE, pulse *_done and err together, rdata = 0.
  - The counter clears on entry to IDLE.
- mem_ready while in IDLE is ignored.
- rdata holds its value until the next completion of the same port.
- A request dropped before its grant is simply not served. Dropping after grant is illegal; the access completes regardless.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State enum (IDLE, IF_BUSY, D_BUSY).
  - Port-select encoding (SEL_IF, SEL_D).
  - Default MAX_D_STREAK and TIMEOUT constants.
- One sub-module, mem_arb_pick: holds the streak counter and produces the one-hot grant select from if_req, d_req and a state==IDLE enable.

Test Plan:
- Fetch only, memory ready after 2 cycles: if_req=1, if_addr=0x100, in_bus=0x1234A0B7 -> mem_rd=1 with mem_addr=0x100 for 2 cycles; then if_done=1 and if_rdata=0x1234A0B7; err=0.
- Store: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_be=4'b0011, mem_ready on the first busy cycle -> mem_wr=1, out_bus=0xDEADBEEF, mem_be=0011 for 1 cycle; then d_done=1.
- Both requesting continuously (MAX_D_STREAK=3) -> grant order D,D,D,IF,D,D,D,IF; if_gnt never pends more than 3 data accesses.
- mem_ready never asserted (TIMEOUT=16) on a load to 0x300 -> mem_rd high for 15 cycles; then d_done=1, err=1, d_rdata=0, state IDLE.
- rst=1 asserted asynchronously mid IF_BUSY -> mem_rd, mem_addr and all pulses go 0 without waiting for a clock edge; no if_done. After release, a pending if_req is re-granted.
- Simultaneous requests arriving in the same cycle as a completion -> no grant in the done cycle; the grant follows one cycle later, data first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter: FSM states,
// the one-hot port-select encoding and the default tuning constants.
package mem_arb_pkg;

  // Data grants allowed in a row while a fetch waits before fetch is forced
  localparam int DEF_MAX_D_STREAK = 3;

  // Busy cycles without mem_ready before an access is abandoned
  localparam int DEF_TIMEOUT = 16;

  // Arbiter FSM: idle, or one access driving the memory port
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_e;

  // One-hot selection of the requester that wins arbitration this cycle
  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_IF   = 2'b01,
    SEL_D    = 2'b10
  } sel_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester handshakes and the shared memory port.
// The slave view belongs to the arbiter; the master view is the
// surrounding core plus memory that drives requests and acknowledges.
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);

  // Instruction-fetch requester
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt;
  logic            if_done;
  logic [XLEN-1:0] if_rdata;

  // Load/store requester
  logic            d_req;
  logic            d_we;
  logic [3:0]      d_be;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_gnt;
  logic            d_done;
  logic [XLEN-1:0] d_rdata;

  // Abort indication, pulses alongside the done of a timed-out access
  logic            err;

  // Shared memory port
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] out_bus;
  logic [3:0]      mem_be;
  logic            mem_rd;
  logic            mem_wr;
  logic [XLEN-1:0] in_bus;
  logic            mem_ready;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  in_bus, mem_ready,
    output if_gnt, if_done, if_rdata,
    output d_gnt, d_done, d_rdata,
    output err,
    output mem_addr, out_bus, mem_be, mem_rd, mem_wr
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output in_bus, mem_ready,
    input  if_gnt, if_done, if_rdata,
    input  d_gnt, d_done, d_rdata,
    input  err,
    input  mem_addr, out_bus, mem_be, mem_rd, mem_wr
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Arbitration decision for the shared memory port. Data requests win by
// default, but after MAX_D_STREAK data grants made while a fetch was
// waiting, the fetch is forced through so instruction fetch never starves.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output sel_e sel_o
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak_q, streak_d;

  // Pick a winner and work out how the starvation streak moves with it;
  // the streak only grows when a data grant overtakes a waiting fetch.
  always_comb begin
    sel_o    = SEL_NONE;
    streak_d = streak_q;
    if (en_i) begin
      if (if_req_i && d_req_i) begin
        if (streak_q == STREAK_MAX) begin
          sel_o    = SEL_IF;
          streak_d = '0;
        end else begin
          sel_o    = SEL_D;
          streak_d = streak_q + 1'b1;
        end
      end else if (if_req_i) begin
        sel_o    = SEL_IF;
        streak_d = '0;
      end else if (d_req_i) begin
        sel_o = SEL_D;
      end
    end
  end

  // Streak counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One access is in flight at a time; strobes are held from registers
// until mem_ready, and an access that never gets mem_ready is abandoned
// after TIMEOUT-1 busy cycles with err raised alongside its done pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  sel_e            sel;
  logic            pickEn;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      be_q;
  logic            we_q;

  logic [TW-1:0]   tmoCnt_q, tmoCnt_d, tmoNext;
  logic            ifDone_q, ifDone_d;
  logic            dDone_q, dDone_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] ifRdata_q, dRdata_q;

  logic            accessEnd;
  logic            accessAbort;
  logic            busy;
  logic            memWr;

  // Arbitrate only in a truly idle cycle: not while a done pulse is out
  // (forces the idle gap between accesses) and never while in reset.
  assign pickEn = (state_q == IDLE) && !ifDone_q && !dDone_q && !rst;

  mem_arb_pick #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .en_i     (pickEn),
    .if_req_i (bus.if_req),
    .d_req_i  (bus.d_req),
    .sel_o    (sel)
  );

  assign tmoNext = tmoCnt_q + 1'b1;

  // Next state, timeout counting and completion/abort decisions.
  always_comb begin
    state_d     = state_q;
    tmoCnt_d    = tmoCnt_q;
    ifDone_d    = 1'b0;
    dDone_d     = 1'b0;
    err_d       = 1'b0;
    accessEnd   = 1'b0;
    accessAbort = 1'b0;
    case (state_q)
      IDLE: begin
        tmoCnt_d = '0;
        if (sel == SEL_IF) begin
          state_d = IF_BUSY;
        end else if (sel == SEL_D) begin
          state_d = D_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (bus.mem_ready) begin
          accessEnd = 1'b1;
        end else if (tmoNext == TMO_LAST) begin
          accessEnd   = 1'b1;
          accessAbort = 1'b1;
        end else begin
          tmoCnt_d = tmoNext;
        end
        if (accessEnd) begin
          state_d  = IDLE;
          tmoCnt_d = '0;
          ifDone_d = (state_q == IF_BUSY);
          dDone_d  = (state_q == D_BUSY);
          err_d    = accessAbort;
        end
      end
      default: begin
        state_d  = IDLE;
        tmoCnt_d = '0;
      end
    endcase
  end

  // State, timeout counter and the registered done/err pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tmoCnt_q <= '0;
      ifDone_q <= 1'b0;
      dDone_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmoCnt_q <= tmoCnt_d;
      ifDone_q <= ifDone_d;
      dDone_q  <= dDone_d;
      err_q    <= err_d;
    end
  end

  // Snapshot the winning request so the memory port never follows the
  // requester inputs once the access has started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else if (sel == SEL_IF) begin
      addr_q  <= bus.if_addr;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else if (sel == SEL_D) begin
      addr_q  <= bus.d_addr;
      wdata_q <= bus.d_wdata;
      be_q    <= bus.d_be;
      we_q    <= bus.d_we;
    end
  end

  // Read data capture; an abort leaves zero behind, a store leaves the
  // previous load data untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifRdata_q <= '0;
      dRdata_q  <= '0;
    end else begin
      if (ifDone_d) begin
        ifRdata_q <= accessAbort ? '0 : bus.in_bus;
      end
      if (dDone_d && (accessAbort || !we_q)) begin
        dRdata_q <= accessAbort ? '0 : bus.in_bus;
      end
    end
  end

  assign busy  = (state_q == IF_BUSY) || (state_q == D_BUSY);
  assign memWr = (state_q == D_BUSY) && we_q;

  assign bus.mem_addr = busy ? addr_q : '0;
  assign bus.mem_rd   = (state_q == IF_BUSY) || ((state_q == D_BUSY) && !we_q);
  assign bus.mem_wr   = memWr;
  assign bus.out_bus  = memWr ? wdata_q : '0;
  assign bus.mem_be   = memWr ? be_q : '0;

  assign bus.if_gnt   = (sel == SEL_IF);
  assign bus.d_gnt    = (sel == SEL_D);
  assign bus.if_done  = ifDone_q;
  assign bus.d_done   = dDone_q;
  assign bus.err      = err_q;
  assign bus.if_rdata = ifRdata_q;
  assign bus.d_rdata  = dRdata_q;

endmodule
